// File: rtl/alu_arb_pkg.sv
// Shared types for the round-robin ALU arbiter.
// Optional macro ALU_ARB_CHAIN_EN enables per-requester carry chaining.
package alu_arb_pkg;
    localparam int ALU_W = 64;

    typedef enum logic [1:0] {
        OP_NOR = 2'b00,
        OP_XOR = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_t;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic             cin;
        op_t              op;
    } alu_req_t;
endpackage

// File: rtl/alu64bit.sv
// 64-bit ALU: NOR, XOR, ADD (a+b+cin), SUB (a+~b+cin).
module alu64bit
    import alu_arb_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic [ALU_W-1:0] s,
    output logic             cout
);
    logic [ALU_W:0] sum;

    always_comb begin
        sum = '0;
        unique case (op_t'(op))
            OP_NOR:  sum = {1'b0, ~(a | b)};
            OP_XOR:  sum = {1'b0, a ^ b};
            OP_ADD:  sum = {1'b0, a} + {1'b0, b} + {{ALU_W{1'b0}}, cin};
            OP_SUB:  sum = {1'b0, a} + {1'b0, ~b} + {{ALU_W{1'b0}}, cin};
            default: sum = '0;
        endcase
    end

    assign {cout, s} = sum;
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; search starts at ptr.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);
    int            t;
    logic [IW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        t       = 0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            t   = (int'(ptr) + k) % N;
            idx = IW'(t);
            if (en && !any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end
endmodule

// File: rtl/alu64bit_arbiter.sv
// One alu64bit shared by NREQ requesters via round-robin arbitration.
// Macro ALU_ARB_CHAIN_EN adds req_chain and per-requester carry registers.
module alu64bit_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ-1:0][ALU_W-1:0]  req_a,
    input  logic [NREQ-1:0][ALU_W-1:0]  req_b,
    input  logic [NREQ-1:0]             req_cin,
    input  logic [NREQ-1:0][1:0]        req_op,
`ifdef ALU_ARB_CHAIN_EN
    input  logic [NREQ-1:0]             req_chain,
`endif
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [IDW-1:0]              rsp_id,
    output logic [ALU_W-1:0]            rsp_s,
    output logic                        rsp_cout
);
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_nxt;
    logic [IDW-1:0]   gnt_idx;
    logic [NREQ-1:0]  gnt;
    logic             any;
    logic             free;
    alu_req_t         win;
    logic [ALU_W-1:0] s;
    logic             cout;

    assign free = !rsp_valid || rsp_ready;

    rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (free && rst_n),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign req_ready = gnt;

`ifdef ALU_ARB_CHAIN_EN
    logic [NREQ-1:0] carry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry <= '0;
        end else if (any) begin
            carry[gnt_idx] <= cout;
        end
    end
`endif

    // gnt_idx is 0 with no winner, so the mux falls back to requester 0.
    always_comb begin
        win.a   = req_a[gnt_idx];
        win.b   = req_b[gnt_idx];
        win.op  = op_t'(req_op[gnt_idx]);
`ifdef ALU_ARB_CHAIN_EN
        win.cin = req_chain[gnt_idx] ? carry[gnt_idx] : req_cin[gnt_idx];
`else
        win.cin = req_cin[gnt_idx];
`endif
    end

    alu64bit u_alu (
        .a    (win.a),
        .b    (win.b),
        .cin  (win.cin),
        .op   (win.op),
        .s    (s),
        .cout (cout)
    );

    assign ptr_nxt = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_s     <= '0;
            rsp_cout  <= 1'b0;
            ptr       <= '0;
        end else if (any) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_idx;
            rsp_s     <= s;
            rsp_cout  <= cout;
            ptr       <= ptr_nxt;
        end else if (free) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu64bit_arbiter.sv
// Scoreboard bench for alu64bit_arbiter (4 requesters).
module tb_alu64bit_arbiter;
    logic             clk;
    logic             rst_n;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [3:0][63:0] req_a;
    logic [3:0][63:0] req_b;
    logic [3:0]       req_cin;
    logic [3:0][1:0]  req_op;
`ifdef ALU_ARB_CHAIN_EN
    logic [3:0]       req_chain;
`endif
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [63:0]      rsp_s;
    logic             rsp_cout;

    typedef struct packed {
        logic [1:0]  id;
        logic [63:0] s;
        logic        c;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   fails;

    alu64bit_arbiter #(.NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_op    (req_op),
`ifdef ALU_ARB_CHAIN_EN
        .req_chain (req_chain),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_s     (rsp_s),
        .rsp_cout  (rsp_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every drained response is compared with the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_rsp: got id %0d none expected", rsp_id);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 64'(rsp_id), 64'(e.id));
                chk("rsp_s", rsp_s, e.s);
                chk("rsp_cout", 64'(rsp_cout), 64'(e.c));
            end
        end
    end

    task automatic issue(input int i, input logic [63:0] a,
                         input logic [63:0] b, input logic cin,
                         input logic [1:0] op, input logic ch,
                         input logic [63:0] es, input logic ec);
        int n;
        req_a[i]   = a;
        req_b[i]   = b;
        req_cin[i] = cin;
        req_op[i]  = op;
`ifdef ALU_ARB_CHAIN_EN
        req_chain[i] = ch;
`else
        if (ch) $display("note: chain ignored");
`endif
        req_valid[i] = 1'b1;
        sb.push_back('{id: 2'(i), s: es, c: ec});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 20);
        if (!req_ready[i]) begin
            checks++;
            fails++;
            $display("FAIL issue_timeout: req %0d got no grant, required one", i);
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    initial begin
        checks    = 0;
        fails     = 0;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
`ifdef ALU_ARB_CHAIN_EN
        req_chain = '0;
`endif
        req_a[0] = 64'h0;                  req_b[0] = 64'h0;
        req_cin[0] = 1'b0;                 req_op[0] = 2'b00;
        req_a[1] = 64'hF0F0_F0F0_F0F0_F0F0; req_b[1] = 64'hFF00_FF00_FF00_FF00;
        req_cin[1] = 1'b0;                 req_op[1] = 2'b01;
        req_a[2] = 64'hFFFF_FFFF_FFFF_FFFF; req_b[2] = 64'h1;
        req_cin[2] = 1'b0;                 req_op[2] = 2'b10;
        req_a[3] = 64'h5;                  req_b[3] = 64'h7;
        req_cin[3] = 1'b1;                 req_op[3] = 2'b11;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_valid", 64'(rsp_valid), 64'h0);
        chk("rst_id", 64'(rsp_id), 64'h0);
        chk("rst_s", rsp_s, 64'h0);
        chk("rst_cout", 64'(rsp_cout), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round-robin over all four requesters, two full rotations.
        for (int r = 0; r < 2; r++) begin
            sb.push_back('{id: 2'd0, s: 64'hFFFF_FFFF_FFFF_FFFF, c: 1'b0});
            sb.push_back('{id: 2'd1, s: 64'h0FF0_0FF0_0FF0_0FF0, c: 1'b0});
            sb.push_back('{id: 2'd2, s: 64'h0, c: 1'b1});
            sb.push_back('{id: 2'd3, s: 64'hFFFF_FFFF_FFFF_FFFE, c: 1'b0});
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_gnt", 64'(req_ready), 64'(1 << (k % 4)));
            chk("rr_valid", 64'(rsp_valid), 64'(k > 0));
            @(posedge clk);
        end
        #1;
        req_valid = 4'b0000;

        issue(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 2'b10, 1'b0,
              64'h0, 1'b1);
        @(posedge clk);
        #1;

        // Backpressure: response from req 0 held while req 1 waits.
        rsp_ready = 1'b0;
        issue(0, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_0000_0000, 1'b0,
              2'b01, 1'b0, 64'hFEDC_BA98_89AB_CDEF, 1'b0);
        req_a[1]     = 64'h0000_0000_FFFF_FFFF;
        req_b[1]     = 64'h0000_FFFF_0000_0000;
        req_cin[1]   = 1'b0;
        req_op[1]    = 2'b00;
        req_valid[1] = 1'b1;
        sb.push_back('{id: 2'd1, s: 64'hFFFF_0000_0000_0000, c: 1'b0});
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready", 64'(req_ready), 64'h0);
            chk("bp_valid", 64'(rsp_valid), 64'h1);
            chk("bp_id", 64'(rsp_id), 64'h0);
            chk("bp_s", rsp_s, 64'hFEDC_BA98_89AB_CDEF);
            @(posedge clk);
        end
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_regrant", 64'(req_ready), 64'h2);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;

        issue(3, 64'h5, 64'h7, 1'b1, 2'b11, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFE, 1'b0);

`ifdef ALU_ARB_CHAIN_EN
        issue(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 2'b10, 1'b0,
              64'h0, 1'b1);
        issue(3, 64'h0, 64'h0, 1'b0, 2'b10, 1'b1, 64'h1, 1'b0);
`endif

        for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: %0d responses left, required 0",
                     sb.size());
        end
        @(negedge clk);
        chk("idle_valid", 64'(rsp_valid), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule

// File: doc/alu64bit_arbiter.md
# alu64bit_arbiter

Shares one `alu64bit` instance among `NREQ` requesters, such as sequencers and test drivers, using a round-robin arbiter. It has one valid/ready request channel per requester and one registered response channel. Each response is tagged with the requester index. Accepted operations take one cycle and run at full throughput: one operation accepted per cycle while the response is drained.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default `$clog2(NREQ)`: width of the requester index.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `req_valid`  in  `[NREQ]`: requester i has an operation pending.
- `req_ready`  out  `[NREQ]`: grant; transfer on `req_valid[i] && req_ready[i]`.
- `req_a`, `req_b`  in  `[NREQ][64]`: operands.
- `req_cin`  in  `[NREQ]`: carry in.
- `req_op`  in  `[NREQ][2]`: ALU operation, passed unchanged to `alu64bit`.
- `rsp_valid`  out  1: the response register holds a result.
- `rsp_ready`  in  1: the consumer accepts the response.
- `rsp_id`  out  `IDW`: index of the requester that issued the result.
- `rsp_s`  out  64: ALU sum/result.
- `rsp_cout`  out  1: ALU carry out.

## Operation
- The response register is free when `!rsp_valid || rsp_ready`.
- The arbiter grants only while the response register is free. At most one `req_ready` bit is high, and only for a requester with `req_valid` set.
- `req_ready` is combinational from `req_valid`, the round-robin pointer and the response-register state.
- Round-robin search starts at pointer `ptr` and continues `ptr`, `ptr+1`, … modulo `NREQ`; the first valid requester wins.
- After a grant to requester g, `ptr` becomes `(g+1) mod NREQ`. With no grant, `ptr` is unchanged.
- The winner's `a`, `b`, `cin` and `op` drive `alu64bit` combinationally through a mux. If there is no winner, the mux selects requester 0; the result is then not captured.
- On a grant, the result registers capture `s`, `cout` and the winner index, and `rsp_valid` is set to 1 on the next edge.
- If the register is free and there is no grant, `rsp_valid` is cleared to 0.
- While `rsp_valid && !rsp_ready`, all response outputs hold stable and every `req_ready` bit is 0.
- A requester may drop `req_valid` before it is granted; no operation is issued for it.
- `req_op` encoding, from the package: `OP_NOR`=00, `OP_XOR`=01, `OP_ADD`=10 (a+b+cin), `OP_SUB`=11. Arithmetic is modulo 2^64, and carry out is taken directly from the ALU.

## Timing
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_s`=0, `rsp_cout`=0, `ptr`=0. `req_ready` is all 0 while `rst_n`=0.
- Reset asserted mid-operation discards any pending response on that edge; requesters must re-present their operations.
- Latency: a request accepted at edge k appears on the response outputs after edge k, i.e. it is valid in cycle k+1.
- Throughput: one operation per cycle while `rsp_ready`=1. Back-to-back grants rotate among the active requesters.
- Simultaneous `rsp_ready` and a new grant in the same cycle: the old response is consumed and the new one is loaded with no bubble.
- Fairness: a requester that holds `req_valid` is granted within `NREQ` grants.

## Configuration
- Macro `ALU_ARB_CHAIN_EN`.
- Defined:
  - Adds input `req_chain` `[NREQ]` and an internal carry register per requester, reset to 0.
  - When the granted requester has `req_chain`=1, the ALU `cin` comes from that requester's carry register and `req_cin` is ignored.
  - Every granted operation writes its `cout` into its requester's carry register.
  - This supports multi-word (128-bit and wider) add/sub issued low word first.
- Undefined:
  - No `req_chain` port and no carry registers.
  - ALU `cin` is always the winner's `req_cin`.

## Structure
- Package `alu_arb_pkg`:
  - `op_t` enum with `OP_NOR`/`OP_XOR`/`OP_ADD`/`OP_SUB`.
  - `alu_req_t` struct containing `a`, `b`, `cin` and `op`.
  - Constant `ALU_W`=64.
- Sub-module `rr_arbiter #(N)`:
  - Inputs: `req[N]`, `ptr`, `en`.
  - Outputs: `gnt[N]` (one-hot), `gnt_idx`, `any`.
  - Purely combinational; the pointer register stays in the top level.
- The top level instantiates `rr_arbiter` once and `alu64bit` once.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with all `req_valid`=1. Expect `req_ready`=0 and all `rsp_*`=0, then a first grant to requester 0 after release.
- **Single ADD:** requester 2 sends a=`64'hFFFF_FFFF_FFFF_FFFF`, b=1, cin=0, op=`OP_ADD`. One cycle later expect `rsp_s`=0, `rsp_cout`=1, `rsp_id`=2.
- **Round-robin:** all 4 requesters valid continuously with `rsp_ready`=1. Expect grant order 0,1,2,3,0,… with `rsp_valid` high every cycle.
- **Backpressure:** `rsp_ready`=0 for 3 cycles while requester 1 is pending. Expect the response held stable and `req_ready`=0; on `rsp_ready`=1, expect the old response drained and requester 1 granted in the same cycle.
- **SUB:** a=5, b=7, cin=1, op=`OP_SUB`. Expect `rsp_s`=`64'hFFFF_FFFF_FFFF_FFFE` and `rsp_cout`=0.
- **Chain (`ALU_ARB_CHAIN_EN`):** requester 3 adds low words `FFFF…FFFF`+1, then high words 0+0 with `req_chain`=1. Expect the second result `rsp_s`=1.
